// File: rtl/dlbf_data_ram2axis.sv
// Streams num_iter repetitions of a block_size-word RAM region out over AXI-Stream.
// Optional backpressure counter enabled by defining DLBF_DATA_RAM2AXIS_STALL_CNT_EN.
module dlbf_data_ram2axis #(
  parameter int DATA_WIDTH       = 64,
  parameter int RAM_READ_LATENCY = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst,
  input  logic                  start,
  input  logic [15:0]           block_size,
  input  logic [15:0]           num_iter,
  output logic                  enb,
  output logic [15:0]           addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [15:0]                 bs_q, ni_q, addr_q, iter_q;
  logic [RAM_READ_LATENCY-1:0] vld_q, lst_q;
  logic [DATA_WIDTH:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [PW:0]                 count_q;
  logic                        done_q, done_d;
  logic                        accept, zero_run, last_addr, last_read, push, pop, empty;
  int unsigned                 outstanding;

  assign accept    = start && (state_q == StIdle);
  assign zero_run  = (block_size == 16'd0) || (num_iter == 16'd0);
  assign last_addr = addr_q == bs_q - 16'd1;
  assign last_read = last_addr && (iter_q == ni_q - 16'd1);
  assign push      = vld_q[RAM_READ_LATENCY-1];
  assign empty     = count_q == '0;
  assign pop       = !empty && m_axis_tready;

  always_comb begin
    outstanding = 0;
    for (int i = 0; i < RAM_READ_LATENCY; i++) outstanding += 32'(vld_q[i]);
  end

  always_comb begin
    state_d = state_q;
    enb     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (zero_run) done_d = 1'b1;
          else          state_d = StRun;
        end
      end
      StRun: begin
        // Reads in flight are counted as occupied so the FIFO can never overflow.
        enb = (outstanding + 32'(count_q)) < 32'(FIFO_DEPTH);
        if (enb && last_read) state_d = StDrain;
      end
      StDrain: begin
        if (outstanding == 0 && empty) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      bs_q     <= '0;
      ni_q     <= '0;
      addr_q   <= '0;
      iter_q   <= '0;
      vld_q    <= '0;
      lst_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        bs_q   <= block_size;
        ni_q   <= num_iter;
        addr_q <= '0;
        iter_q <= '0;
      end else if (enb) begin
        if (last_addr) begin
          addr_q <= '0;
          iter_q <= iter_q + 16'd1;
        end else begin
          addr_q <= addr_q + 16'd1;
        end
      end
      vld_q <= (vld_q << 1) | RAM_READ_LATENCY'(enb);
      lst_q <= (lst_q << 1) | RAM_READ_LATENCY'(enb && last_addr);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge m_axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= {lst_q[RAM_READ_LATENCY-1], doutb};
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_axis_tlast  = empty ? 1'b0 : mem_q[rd_ptr_q][DATA_WIDTH];
  assign addrb         = addr_q;
  assign busy          = state_q != StIdle;
  assign done          = done_q;

`ifdef DLBF_DATA_RAM2AXIS_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
    if (m_axis_rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dlbf_data_ram2axis.sv
// Directed bench for dlbf_data_ram2axis with a latency-4 RAM model returning data = address.
module tb_dlbf_data_ram2axis;

  logic        m_axis_clk = 1'b0;
  logic        m_axis_rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] block_size = '0;
  logic [15:0] num_iter = '0;
  logic        enb;
  logic [15:0] addrb;
  logic [63:0] doutb;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [31:0] stall_cnt;

  dlbf_data_ram2axis dut (
    .m_axis_clk   (m_axis_clk),
    .m_axis_rst   (m_axis_rst),
    .start        (start),
    .block_size   (block_size),
    .num_iter     (num_iter),
    .enb          (enb),
    .addrb        (addrb),
    .doutb        (doutb),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done),
    .stall_cnt    (stall_cnt)
  );

  always #5 m_axis_clk = ~m_axis_clk;

  // RAM port B: doutb in cycle n reflects addrb from cycle n-4.
  logic [15:0] p0, p1, p2, p3;
  always @(posedge m_axis_clk) begin
    p0 <= addrb;
    p1 <= p0;
    p2 <= p1;
    p3 <= p2;
  end
  assign doutb = {48'd0, p3};

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 random
  bit mon_clr  = 1'b0;

  int          cyc = 0;
  int          start_cyc, first_cyc, last_cyc, done_cyc;
  int          n_enb, issued, popped, max_occ, stalls, stab_err, done_cnt;
  bit          hold;
  logic [63:0] hold_data;
  logic        hold_last;
  logic [63:0] beats_d[$];
  logic        beats_l[$];
  logic [15:0] rd_addrs[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  initial forever begin
    @(posedge m_axis_clk);
    #1;
    unique case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  end

  initial forever begin
    @(negedge m_axis_clk);
    cyc++;
    if (mon_clr) begin
      start_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1;
      n_enb = 0; issued = 0; popped = 0; max_occ = 0; stalls = 0; stab_err = 0;
      done_cnt = 0; hold = 1'b0;
      beats_d.delete(); beats_l.delete(); rd_addrs.delete();
    end else begin
      if (start && !busy && start_cyc < 0) start_cyc = cyc;
      if (enb) begin
        n_enb++;
        issued++;
        rd_addrs.push_back(addrb);
      end
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (m_axis_tvalid && first_cyc < 0) first_cyc = cyc;
      if (hold && (m_axis_tdata !== hold_data || m_axis_tlast !== hold_last)) stab_err++;
      hold      = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        beats_d.push_back(m_axis_tdata);
        beats_l.push_back(m_axis_tlast);
        last_cyc = cyc;
        popped++;
      end
      if (m_axis_tvalid && !m_axis_tready) stalls++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge m_axis_clk);
      #1;
    end
  endtask

  task automatic launch(input logic [15:0] bs, input logic [15:0] ni);
    mon_clr = 1'b1;
    step(1);
    mon_clr    = 1'b0;
    block_size = bs;
    num_iter   = ni;
    start      = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    step(3);
    check("done_once", 64'(done_cnt), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_stream(input int bs, input int ni);
    check("beats", 64'(beats_d.size()), 64'(bs * ni));
    for (int k = 0; k < beats_d.size() && k < bs * ni; k++) begin
      check($sformatf("data[%0d]", k), beats_d[k], 64'(k % bs));
      check($sformatf("last[%0d]", k), 64'(beats_l[k]), 64'((k % bs) == bs - 1));
    end
  endtask

  task automatic check_stall();
`ifdef DLBF_DATA_RAM2AXIS_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`else
    check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
  endtask

  initial begin
    logic [15:0] zbs [2];
    logic [15:0] zni [2];
    int          n;
    zbs[0] = 16'd0; zni[0] = 16'd3;
    zbs[1] = 16'd7; zni[1] = 16'd0;

    #1;
    check("rst_ctrl", 64'({enb, addrb, m_axis_tvalid, m_axis_tlast, busy, done}), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    step(3);
    m_axis_rst = 1'b0;
    step(2);

    // 16 x 1, tready high: latency, throughput, ordering
    launch(16'd16, 16'd1);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done(200);
    check_stream(16, 1);
    check("first_latency", 64'(first_cyc - start_cyc), 64'd6);
    check("no_bubbles", 64'(last_cyc - first_cyc), 64'd15);
    check("done_after_last", 64'(done_cyc > last_cyc), 64'd1);

    // 5 x 3 with a start pulse while busy that must be ignored
    mon_clr = 1'b1;
    step(1);
    mon_clr    = 1'b0;
    block_size = 16'd5;
    num_iter   = 16'd3;
    start      = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    block_size = 16'd2;
    num_iter   = 16'd1;
    start      = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(200);
    check_stream(5, 3);
    check("reads", 64'(n_enb), 64'd15);
    if (rd_addrs.size() >= 6) begin
      check("addr_pre_wrap", 64'(rd_addrs[4]), 64'd4);
      check("addr_wrap", 64'(rd_addrs[5]), 64'd0);
    end else begin
      check("addr_count", 64'(rd_addrs.size()), 64'd15);
    end
    check("no_bubbles_5x3", 64'(last_cyc - first_cyc), 64'd14);

    // 64 x 1, random backpressure
    rdy_mode = 2;
    launch(16'd64, 16'd1);
    wait_done(2000);
    check_stream(64, 1);
    check("occ_le_depth", 64'(max_occ <= 8), 64'd1);
    check("stable_random", 64'(stab_err), 64'd0);
    check_stall();
    rdy_mode = 1;
    step(2);

    // tready low for 100 cycles
    rdy_mode = 0;
    step(2);
    launch(16'd16, 16'd1);
    step(99);
    check("reads_blocked", 64'(n_enb), 64'd8);
    check("occ_full", 64'(max_occ), 64'd8);
    check("tvalid_held", 64'(m_axis_tvalid), 64'd1);
    check("tdata_held", m_axis_tdata, 64'd0);
    check("stable_low", 64'(stab_err), 64'd0);
    check_stall();
    rdy_mode = 1;
    wait_done(200);
    check_stream(16, 1);

    // reset after beat 7 of a 32-word run
    launch(16'd32, 16'd1);
    n = 0;
    while (beats_d.size() < 7 && n < 100) begin
      step(1);
      n++;
    end
    check("reached_beat7", 64'(beats_d.size() >= 7), 64'd1);
    m_axis_rst = 1'b1;
    #1;
    check("midrst_ctrl", 64'({enb, addrb, m_axis_tvalid, m_axis_tlast, busy, done}), 64'd0);
    check("midrst_tdata", m_axis_tdata, 64'd0);
    check("midrst_stall", 64'(stall_cnt), 64'd0);
    step(2);
    m_axis_rst = 1'b0;
    step(4);
    check("no_done_on_abort", 64'(done_cnt), 64'd0);
    launch(16'd32, 16'd1);
    wait_done(300);
    check_stream(32, 1);
    if (rd_addrs.size() > 0) check("restart_addr0", 64'(rd_addrs[0]), 64'd0);
    else check("restart_reads", 64'd0, 64'd32);

    // zero-size starts
    for (int t = 0; t < 2; t++) begin
      launch(zbs[t], zni[t]);
      step(4);
      check($sformatf("zero%0d_done", t), 64'(done_cnt), 64'd1);
      check($sformatf("zero%0d_lat", t), 64'(done_cyc - start_cyc), 64'd1);
      check($sformatf("zero%0d_enb", t), 64'(n_enb), 64'd0);
      check($sformatf("zero%0d_tvalid", t), 64'(first_cyc < 0), 64'd1);
      check($sformatf("zero%0d_busy", t), 64'(busy), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dlbf_data_ram2axis.md
DLBF_DATA_RAM2AXIS -- requirements
Module: dlbf_data_ram2axis

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 64, tdata/doutb width; RAM_READ_LATENCY 4, enb-to-doutb cycles of the attached RAM port B; FIFO_DEPTH 8, output FIFO words, power of two, >= RAM_READ_LATENCY+2.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: m_axis_clk  in  1  sole clock; m_axis_rst  in  1  async active-high reset.
REQ-003 Ports SHALL be: start  in  1  run request pulse; block_size  in  16  words per block; num_iter  in  16  block repetitions.
REQ-004 Ports SHALL be: enb  out  1  RAM port-B enable; addrb  out  16  RAM port-B word address; doutb  in  DATA_WIDTH  RAM port-B read data.
REQ-005 Ports SHALL be: m_axis_tdata  out  DATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1  last word of each block.
REQ-006 Ports SHALL be: busy  out  1  run in progress; done  out  1  one-cycle completion pulse; stall_cnt  out  32  backpressure cycle count.

Function
REQ-007 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start with block_size!=0 and num_iter!=0; RUN->DRAIN after the last read is issued; DRAIN->IDLE when no reads are outstanding, the FIFO is empty and the last beat has handshaken.
REQ-008 start with block_size==0 or num_iter==0 SHALL produce done one cycle later without entering RUN or issuing reads.
REQ-009 block_size and num_iter SHALL be latched on accepted start; start while busy SHALL be ignored.
REQ-010 In RUN, enb SHALL assert only when outstanding reads plus FIFO occupancy < FIFO_DEPTH, so the FIFO never overflows.
REQ-011 addrb SHALL start at 0, increment by 1 per issued read, and wrap to 0 after block_size-1 to begin the next iteration.
REQ-012 A RAM_READ_LATENCY-deep valid/tlast shift register SHALL accompany each read; doutb SHALL be written to the FIFO exactly RAM_READ_LATENCY cycles after its enb.
REQ-013 m_axis_tvalid SHALL equal FIFO not-empty; tdata/tlast SHALL be held stable while tvalid && !tready.
REQ-014 m_axis_tlast SHALL accompany the word read from address block_size-1 of every iteration.
REQ-015 Latency from accepted start to first tvalid SHALL be RAM_READ_LATENCY+2 cycles with tready high.
REQ-016 With tready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-017 busy SHALL be high from the cycle after accepted start until the cycle done pulses; done SHALL pulse once per run.
REQ-018 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; pop from empty and push to full SHALL not occur.

Reset
REQ-019 Asserting m_axis_rst SHALL immediately force state IDLE, empty the FIFO and clear the shift register, and drive enb, addrb, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done and stall_cnt to 0.
REQ-020 Reset mid-run SHALL abort the run without a done pulse; the first start after deassertion SHALL begin at address 0.

Configuration
REQ-021 With macro DLBF_DATA_RAM2AXIS_STALL_CNT_EN defined, stall_cnt SHALL increment, saturating at 2^32-1, each cycle m_axis_tvalid && !m_axis_tready, and clear on accepted start.
REQ-022 Without DLBF_DATA_RAM2AXIS_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-023 RAM model with data=address; block_size=16, num_iter=1, tready=1 -> 16 beats 0..15, tlast on beat 15, first tvalid 6 cycles after start, done once.
REQ-024 block_size=5, num_iter=3 -> 15 beats 0..4 repeated, tlast on beats 5, 10 and 15, addrb wraps 4->0.
REQ-025 block_size=64, tready toggled randomly at 50% -> all 64 words in order with no loss or duplication, outstanding+occupancy never exceeds 8, stall_cnt equals the counted stall cycles when the macro is defined.
REQ-026 tready held low for 100 cycles after start -> enb stops after 8 reads, tdata stable, run completes normally after tready is released.
REQ-027 m_axis_rst asserted at beat 7 of a 32-word run -> all outputs 0 immediately, no done; a new start yields a full 32-beat run from address 0.
REQ-028 start with block_size=0 -> done pulse after 1 cycle, no enb, no tvalid; start asserted while busy -> ignored.
